// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// downstream hold; inserts NOP bubbles and counts them in a saturating counter.
module id_ex_pipe #(
    parameter logic [31:0] NOP  = 32'h0000_0013,
    parameter int          CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     id_ir,
    input  logic [31:0]     id_pc,
    input  logic [31:0]     rs1_data,
    input  logic [31:0]     rs2_data,
    input  logic            flush,
    input  logic            hold,
    output logic            stall,
    output logic [31:0]     ex_ir,
    output logic [31:0]     ex_pc,
    output logic [31:0]     ex_rs1,
    output logic [31:0]     ex_rs2,
    output logic [31:0]     ex_imm,
    output logic            ex_sel,
    output logic            ex_valid,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_U   = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic {RUN, LDSTALL} state_t;

    state_t state_q, state_d;

    logic        [31:0]     ir_p1, pc_p1, rs1_p1, rs2_p1;
    logic signed [31:0]     imm_p1;
    logic                   sel_p1, vld_p1;
    logic        [CNTW-1:0] cnt_p1;

    logic hazard, load_id, load_bubble;

    function automatic logic signed [31:0] imm_gen(input logic [31:0] ir);
        case (ir[6:0])
            OP_I, OP_LW: imm_gen = {{20{ir[31]}}, ir[31:20]};
            OP_S:        imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_B:        imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_JAL:      imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            OP_U:        imm_gen = {ir[31:12], 12'b0};
            default:     imm_gen = '0;
        endcase
    endfunction

    function automatic logic sel_gen(input logic [31:0] ir);
        sel_gen = !(ir[6:0] == OP_R || ir[6:0] == OP_B);
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ir);
        uses_rs1 = (ir[6:0] == OP_R) || (ir[6:0] == OP_I) || (ir[6:0] == OP_LW) ||
                   (ir[6:0] == OP_S) || (ir[6:0] == OP_B);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        uses_rs2 = (ir[6:0] == OP_R) || (ir[6:0] == OP_S) || (ir[6:0] == OP_B);
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        sat_inc = (&c) ? c : c + 1'b1;
    endfunction

    // A load in EX whose destination feeds the ID instruction needs one bubble.
    assign hazard = (ir_p1[6:0] == OP_LW) && (ir_p1[11:7] != 5'd0) &&
                    ((uses_rs1(id_ir) && id_ir[19:15] == ir_p1[11:7]) ||
                     (uses_rs2(id_ir) && id_ir[24:20] == ir_p1[11:7]));

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        load_id     = 1'b0;
        load_bubble = 1'b0;
        if (flush) begin
            load_bubble = 1'b1;
            state_d     = RUN;
        end else if (hold) begin
            stall = 1'b1;
        end else if (hazard) begin
            load_bubble = 1'b1;
            stall       = 1'b1;
            state_d     = LDSTALL;
        end else begin
            load_id = 1'b1;
            state_d = RUN;
        end
    end

    // ID -> EX stage boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            ir_p1   <= NOP;
            pc_p1   <= '0;
            rs1_p1  <= '0;
            rs2_p1  <= '0;
            imm_p1  <= '0;
            sel_p1  <= 1'b1;
            vld_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            state_q <= state_d;
            if (load_bubble) begin
                ir_p1  <= NOP;
                pc_p1  <= '0;
                rs1_p1 <= '0;
                rs2_p1 <= '0;
                imm_p1 <= '0;
                sel_p1 <= 1'b1;
                vld_p1 <= 1'b0;
                cnt_p1 <= sat_inc(cnt_p1);
            end else if (load_id) begin
                ir_p1  <= id_ir;
                pc_p1  <= id_pc;
                rs1_p1 <= rs1_data;
                rs2_p1 <= rs2_data;
                imm_p1 <= imm_gen(id_ir);
                sel_p1 <= sel_gen(id_ir);
                vld_p1 <= 1'b1;
            end
        end
    end

    // EX holds a bubble while in LDSTALL, so a second load-use hazard is impossible.
    ldstall_no_hazard: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == LDSTALL && hazard));

    assign ex_ir      = ir_p1;
    assign ex_pc      = pc_p1;
    assign ex_rs1     = rs1_p1;
    assign ex_rs2     = rs2_p1;
    assign ex_imm     = imm_p1;
    assign ex_sel     = sel_p1;
    assign ex_valid   = vld_p1;
    assign bubble_cnt = cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus randomized instruction streams,
// compared against a transaction-level model of the EX register contents.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_ir, id_pc, rs1_data, rs2_data;
    logic        flush, hold;
    logic        stall;
    logic [31:0] ex_ir, ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic        ex_sel, ex_valid;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    // Expected EX contents
    logic [31:0] m_ir, m_pc, m_rs1, m_rs2, m_imm;
    logic        m_sel, m_valid;
    int          m_cnt;

    id_ex_pipe #(.NOP(32'h0000_0013), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .id_ir(id_ir), .id_pc(id_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .hold(hold),
        .stall(stall), .ex_ir(ex_ir), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_sel(ex_sel), .ex_valid(ex_valid),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string kind(input logic [31:0] ir);
        case (ir[6:0])
            7'b0110011: return "R";
            7'b0010011: return "I";
            7'b0000011: return "LW";
            7'b0100011: return "S";
            7'b1100011: return "B";
            7'b0110111: return "U";
            7'b1101111: return "J";
            default:    return "X";
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ir);
        logic [31:0] w;
        w = ir;
        case (kind(ir))
            "I", "LW": return 32'(int'($signed(w[31:20])));
            "S":       return 32'(int'($signed({w[31:25], w[11:7]})));
            "B":       return 32'(2 * int'($signed({w[31], w[7], w[30:25], w[11:8]})));
            "J":       return 32'(2 * int'($signed({w[31], w[19:12], w[20], w[30:21]})));
            "U":       return w & 32'hFFFF_F000;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic ref_hazard(input logic [31:0] ir);
        string k;
        logic [31:0] e;
        int rd;
        k  = kind(ir);
        e  = m_ir;
        rd = int'(e[11:7]);
        if (kind(e) != "LW" || rd == 0) return 1'b0;
        if ((k == "R" || k == "I" || k == "LW" || k == "S" || k == "B") && int'(ir[19:15]) == rd)
            return 1'b1;
        if ((k == "R" || k == "S" || k == "B") && int'(ir[24:20]) == rd)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_bubble();
        m_ir = 32'h13; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
        m_sel = 1'b1; m_valid = 1'b0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ir"}, ex_ir, m_ir);
        chk({tag, ".pc"}, ex_pc, m_pc);
        chk({tag, ".rs1"}, ex_rs1, m_rs1);
        chk({tag, ".rs2"}, ex_rs2, m_rs2);
        chk({tag, ".imm"}, ex_imm, m_imm);
        chk({tag, ".sel"}, 32'(ex_sel), 32'(m_sel));
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
        chk({tag, ".cnt"}, 32'(bubble_cnt), 32'(m_cnt));
    endtask

    task automatic step(input string tag, input logic f, input logic h,
                        input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
        logic haz;
        @(negedge clk);
        flush = f; hold = h; id_ir = ir; id_pc = pc; rs1_data = a; rs2_data = b;
        #1;
        haz = ref_hazard(ir);
        chk({tag, ".stall"}, 32'(stall), 32'(!f && (h || haz)));
        @(posedge clk);
        if (f || (!h && haz)) begin
            model_bubble();
            if (m_cnt < 16'hFFFF) m_cnt++;
        end else if (!h) begin
            m_ir = ir; m_pc = pc; m_rs1 = a; m_rs2 = b;
            m_imm = ref_imm(ir); m_sel = !(kind(ir) == "R" || kind(ir) == "B");
            m_valid = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [6:0] ops [8];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b1101111, 7'b1111111};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 7)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        rst = 1'b0; flush = 0; hold = 0;
        id_ir = 0; id_pc = 0; rs1_data = 0; rs2_data = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) rst = 1'b1;

        // Load-use on x1: one bubble, then the add enters EX
        step("lw_x1", 0, 0, 32'h0000_2083, 32'h100, 32'h11, 32'h22);
        step("hazard", 0, 0, 32'h0010_8133, 32'h104, 32'h33, 32'h44);
        chk("hazard.nop", ex_ir, 32'h0000_0013);
        chk("hazard.cnt1", 32'(bubble_cnt), 32'd1);
        step("after_hazard", 0, 0, 32'h0010_8133, 32'h104, 32'h33, 32'h44);
        chk("after_hazard.add", ex_ir, 32'h0010_8133);

        // Load to x0 never stalls
        step("lw_x0", 0, 0, 32'h0000_2003, 32'h200, 1, 2);
        step("x0_use", 0, 0, 32'h0000_0033, 32'h204, 3, 4);
        chk("x0_use.valid", 32'(ex_valid), 32'd1);

        // Hazard and flush together: flush wins, no stall
        step("lw_x1b", 0, 0, 32'h0000_2083, 32'h300, 5, 6);
        step("haz_flush", 1, 0, 32'h0010_8133, 32'h304, 7, 8);
        chk("haz_flush.nop", ex_ir, 32'h0000_0013);
        step("post_flush", 0, 0, 32'h0000_0033, 32'h308, 9, 10);

        // Hold freezes EX for three cycles, then addi x1,x0,5 loads
        for (int i = 0; i < 3; i++) step("hold", 0, 1, 32'h0050_0093, 32'h400, 0, 0);
        step("release", 0, 0, 32'h0050_0093, 32'h400, 0, 0);
        chk("release.imm5", ex_imm, 32'd5);

        // Immediates, and a NOP passed through normally stays valid
        step("imm_b", 0, 0, 32'hFE00_0EE3, 32'h500, 0, 0);
        chk("imm_b.value", ex_imm, 32'hFFFF_FFFC);
        chk("imm_b.sel", 32'(ex_sel), 32'd0);
        step("imm_u", 0, 0, 32'h1234_50B7, 32'h504, 0, 0);
        chk("imm_u.value", ex_imm, 32'h1234_5000);
        step("real_nop", 0, 0, 32'h0000_0013, 32'h508, 0, 0);

        // Reset while in LDSTALL drops the stall; next edge is a normal load
        step("lw_x1c", 0, 0, 32'h0000_2083, 32'h600, 1, 1);
        step("haz2", 0, 0, 32'h0010_8133, 32'h604, 2, 2);
        @(negedge clk) rst = 1'b0;
        #1 model_reset();
        check_all("rst_stall");
        @(negedge clk) rst = 1'b1;
        step("after_rst", 0, 0, 32'h0010_8133, 32'h604, 2, 2);

        // Randomized stream
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 rand_ir(), $urandom, $urandom, $urandom);

        // Drive the counter up to saturation with flushes
        while (m_cnt < 16'hFFFE) step("fill", 1, 0, rand_ir(), $urandom, 0, 0);
        for (int i = 0; i < 3; i++) step("sat", 1, 0, 32'h0000_0033, 0, 0, 0);
        chk("sat.ffff", 32'(bubble_cnt), 32'hFFFF);
        step("load_before_rst", 0, 0, 32'h0050_0093, 32'h700, 3, 4);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk) rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
